id_ex_operand_stage: RTL and testbench

//  ID/EX pipeline register with operand forwarding and load-use hazard detection. It sits directly upstream
//  of the ALU. It captures one decoded instruction per cycle and resolves rs1/rs2 against in-flight results.
//  It drives registered operand1/operand2/ALU_op into the ALU and holds the control fields consumed by MEM.

---
 rtl/id_ex_operand_stage_pkg.sv | 20 ++
 rtl/id_ex_operand_stage_operand_fwd_mux.sv | 35 +++
 rtl/id_ex_operand_stage.sv | 170 +++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_operand_stage_pkg.sv
// Shared ALU opcode constants and default datapath widths for the ID/EX operand stage.
package id_ex_operand_stage_pkg;

  localparam int unsigned BIT_WIDTH_DEF = 32;
  localparam int unsigned REG_BITS_DEF  = 4;
  localparam int unsigned OP_BITS_DEF   = 5;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_XOR = 5'b00100;
  localparam logic [4:0] ALU_SLL = 5'b00101;
  localparam logic [4:0] ALU_SRL = 5'b00110;
  localparam logic [4:0] ALU_SRA = 5'b00111;
  localparam logic [4:0] ALU_SLT = 5'b01000;
  // ALU_F is the do-nothing op carried by bubbles.
  localparam logic [4:0] ALU_F   = 5'b01001;

endpackage

// File: rtl/id_ex_operand_stage_operand_fwd_mux.sv
// Three-source priority operand mux: EX result, then MEM result, then register file data.
module operand_fwd_mux
  import id_ex_operand_stage_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = BIT_WIDTH_DEF,
  parameter int unsigned REG_BITS  = REG_BITS_DEF
) (
  input  logic [REG_BITS-1:0]  i_src_idx,
  input  logic [BIT_WIDTH-1:0] i_rf_data,
  input  logic                 i_ex_fwd_en,
  input  logic [REG_BITS-1:0]  i_ex_rd,
  input  logic [BIT_WIDTH-1:0] i_ex_data,
  input  logic                 i_mem_fwd_en,
  input  logic [REG_BITS-1:0]  i_mem_rd,
  input  logic [BIT_WIDTH-1:0] i_mem_data,
  output logic [BIT_WIDTH-1:0] o_data_c
);

  logic w_ex_hit;
  logic w_mem_hit;

  assign w_ex_hit  = i_ex_fwd_en  && (i_ex_rd  == i_src_idx);
  assign w_mem_hit = i_mem_fwd_en && (i_mem_rd == i_src_idx);

  // Newest producer wins.
  always_comb begin
    o_data_c = i_rf_data;
    if (w_ex_hit) begin
      o_data_c = i_ex_data;
    end else if (w_mem_hit) begin
      o_data_c = i_mem_data;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with per-source operand forwarding and load-use stall generation.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = BIT_WIDTH_DEF,
  parameter int unsigned REG_BITS  = REG_BITS_DEF,
  parameter int unsigned OP_BITS   = OP_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec_valid,
  input  logic [REG_BITS-1:0]  dec_rs1,
  input  logic [REG_BITS-1:0]  dec_rs2,
  input  logic                 dec_use_rs1,
  input  logic                 dec_use_rs2,
  input  logic [BIT_WIDTH-1:0] dec_rs1_data,
  input  logic [BIT_WIDTH-1:0] dec_rs2_data,
  input  logic [BIT_WIDTH-1:0] dec_imm,
  input  logic                 dec_use_imm,
  input  logic [OP_BITS-1:0]   dec_alu_op,
  input  logic [REG_BITS-1:0]  dec_rd,
  input  logic                 dec_reg_wr,
  input  logic                 dec_mem_rd,
  input  logic                 dec_mem_wr,
  input  logic [BIT_WIDTH-1:0] dec_pc,
  input  logic [BIT_WIDTH-1:0] ex_alu_out,
  input  logic [REG_BITS-1:0]  mem_rd_idx,
  input  logic                 mem_reg_wr,
  input  logic [BIT_WIDTH-1:0] mem_result,
  input  logic                 flush,
  output logic                 stall,
  output logic                 ex_valid,
  output logic [BIT_WIDTH-1:0] ex_operand1,
  output logic [BIT_WIDTH-1:0] ex_operand2,
  output logic [BIT_WIDTH-1:0] ex_store_dat,
  output logic [OP_BITS-1:0]   ex_alu_op,
  output logic [REG_BITS-1:0]  ex_rd,
  output logic                 ex_reg_wr,
  output logic                 ex_mem_rd,
  output logic                 ex_mem_wr,
  output logic [BIT_WIDTH-1:0] ex_pc
);

  localparam logic [OP_BITS-1:0] BUBBLE_OP = OP_BITS'(ALU_F);

  logic                 r_valid;
  logic [BIT_WIDTH-1:0] r_operand1;
  logic [BIT_WIDTH-1:0] r_operand2;
  logic [BIT_WIDTH-1:0] r_store_dat;
  logic [OP_BITS-1:0]   r_alu_op;
  logic [REG_BITS-1:0]  r_rd;
  logic                 r_reg_wr;
  logic                 r_mem_rd;
  logic                 r_mem_wr;
  logic [BIT_WIDTH-1:0] r_pc;

  logic                 w_ex_fwd_en;
  logic [BIT_WIDTH-1:0] w_fwd1;
  logic [BIT_WIDTH-1:0] w_fwd2;
  logic                 w_lu;
  logic                 w_capture;

  logic                 w_nxt_valid;
  logic [BIT_WIDTH-1:0] w_nxt_operand1;
  logic [BIT_WIDTH-1:0] w_nxt_operand2;
  logic [BIT_WIDTH-1:0] w_nxt_store_dat;
  logic [OP_BITS-1:0]   w_nxt_alu_op;
  logic [REG_BITS-1:0]  w_nxt_rd;
  logic                 w_nxt_reg_wr;
  logic                 w_nxt_mem_rd;
  logic                 w_nxt_mem_wr;
  logic [BIT_WIDTH-1:0] w_nxt_pc;

  // A held load's data is not ready yet, so it never forwards from EX.
  assign w_ex_fwd_en = r_valid && r_reg_wr && !r_mem_rd;

  operand_fwd_mux #(.BIT_WIDTH(BIT_WIDTH), .REG_BITS(REG_BITS)) u_fwd_rs1 (
    .i_src_idx    (dec_rs1),
    .i_rf_data    (dec_rs1_data),
    .i_ex_fwd_en  (w_ex_fwd_en),
    .i_ex_rd      (r_rd),
    .i_ex_data    (ex_alu_out),
    .i_mem_fwd_en (mem_reg_wr),
    .i_mem_rd     (mem_rd_idx),
    .i_mem_data   (mem_result),
    .o_data_c     (w_fwd1)
  );

  operand_fwd_mux #(.BIT_WIDTH(BIT_WIDTH), .REG_BITS(REG_BITS)) u_fwd_rs2 (
    .i_src_idx    (dec_rs2),
    .i_rf_data    (dec_rs2_data),
    .i_ex_fwd_en  (w_ex_fwd_en),
    .i_ex_rd      (r_rd),
    .i_ex_data    (ex_alu_out),
    .i_mem_fwd_en (mem_reg_wr),
    .i_mem_rd     (mem_rd_idx),
    .i_mem_data   (mem_result),
    .o_data_c     (w_fwd2)
  );

  assign w_lu = dec_valid && r_valid && r_mem_rd && r_reg_wr &&
                ((dec_use_rs1 && (dec_rs1 == r_rd)) || (dec_use_rs2 && (dec_rs2 == r_rd)));

  assign stall     = w_lu && !flush && !reset;
  assign w_capture = dec_valid && !flush && !w_lu;

  // Next held instruction: a bubble unless a real, unblocked instruction is decoded.
  always_comb begin
    w_nxt_valid     = 1'b0;
    w_nxt_operand1  = '0;
    w_nxt_operand2  = '0;
    w_nxt_store_dat = '0;
    w_nxt_alu_op    = BUBBLE_OP;
    w_nxt_rd        = '0;
    w_nxt_reg_wr    = 1'b0;
    w_nxt_mem_rd    = 1'b0;
    w_nxt_mem_wr    = 1'b0;
    w_nxt_pc        = '0;
    if (w_capture) begin
      w_nxt_valid     = dec_valid;
      w_nxt_operand1  = w_fwd1;
      w_nxt_operand2  = dec_use_imm ? dec_imm : w_fwd2;
      w_nxt_store_dat = w_fwd2;
      w_nxt_alu_op    = dec_alu_op;
      w_nxt_rd        = dec_rd;
      w_nxt_reg_wr    = dec_reg_wr && dec_valid;
      w_nxt_mem_rd    = dec_mem_rd && dec_valid;
      w_nxt_mem_wr    = dec_mem_wr && dec_valid;
      w_nxt_pc        = dec_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_operand1  <= '0;
      r_operand2  <= '0;
      r_store_dat <= '0;
      r_alu_op    <= BUBBLE_OP;
      r_rd        <= '0;
      r_reg_wr    <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_pc        <= '0;
    end else begin
      r_valid     <= w_nxt_valid;
      r_operand1  <= w_nxt_operand1;
      r_operand2  <= w_nxt_operand2;
      r_store_dat <= w_nxt_store_dat;
      r_alu_op    <= w_nxt_alu_op;
      r_rd        <= w_nxt_rd;
      r_reg_wr    <= w_nxt_reg_wr;
      r_mem_rd    <= w_nxt_mem_rd;
      r_mem_wr    <= w_nxt_mem_wr;
      r_pc        <= w_nxt_pc;
    end
  end

  assign ex_valid     = r_valid;
  assign ex_operand1  = r_operand1;
  assign ex_operand2  = r_operand2;
  assign ex_store_dat = r_store_dat;
  assign ex_alu_op    = r_alu_op;
  assign ex_rd        = r_rd;
  assign ex_reg_wr    = r_reg_wr;
  assign ex_mem_rd    = r_mem_rd;
  assign ex_mem_wr    = r_mem_wr;
  assign ex_pc        = r_pc;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed and randomized checks of id_ex_operand_stage against an instruction-level model.
module tb_id_ex_operand_stage;
  import id_ex_operand_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid;
  logic [3:0]  dec_rs1, dec_rs2, dec_rd, mem_rd_idx, ex_rd;
  logic        dec_use_rs1, dec_use_rs2, dec_use_imm;
  logic [31:0] dec_rs1_data, dec_rs2_data, dec_imm, dec_pc;
  logic [4:0]  dec_alu_op, ex_alu_op;
  logic        dec_reg_wr, dec_mem_rd, dec_mem_wr;
  logic [31:0] ex_alu_out, mem_result;
  logic        mem_reg_wr, flush, stall;
  logic        ex_valid, ex_reg_wr, ex_mem_rd, ex_mem_wr;
  logic [31:0] ex_operand1, ex_operand2, ex_store_dat, ex_pc;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data),
    .dec_imm(dec_imm), .dec_use_imm(dec_use_imm), .dec_alu_op(dec_alu_op),
    .dec_rd(dec_rd), .dec_reg_wr(dec_reg_wr), .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr),
    .dec_pc(dec_pc), .ex_alu_out(ex_alu_out),
    .mem_rd_idx(mem_rd_idx), .mem_reg_wr(mem_reg_wr), .mem_result(mem_result),
    .flush(flush), .stall(stall), .ex_valid(ex_valid),
    .ex_operand1(ex_operand1), .ex_operand2(ex_operand2), .ex_store_dat(ex_store_dat),
    .ex_alu_op(ex_alu_op), .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_pc(ex_pc)
  );

  // Model of the instruction the stage should currently be holding.
  typedef struct {
    logic        valid;
    logic [31:0] op1, op2, sd;
    logic [4:0]  op;
    logic [3:0]  rd;
    logic        wr, mrd, mwr;
    logic [31:0] pc;
  } slot_t;

  slot_t m;
  int    n_total = 0;
  int    n_pass  = 0;
  int    n_fail  = 0;
  logic  last_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic slot_t empty_slot();
    slot_t s;
    s.valid = 1'b0; s.op1 = 32'h0; s.op2 = 32'h0; s.sd = 32'h0; s.op = ALU_F;
    s.rd = 4'h0; s.wr = 1'b0; s.mrd = 1'b0; s.mwr = 1'b0; s.pc = 32'h0;
    return s;
  endfunction

  // Value a source register really has right now, looking at newest producers first.
  function automatic logic [31:0] reg_value(input logic [3:0] idx, input logic [31:0] rf);
    if (m.valid && m.wr && !m.mrd && m.rd == idx) return ex_alu_out;
    if (mem_reg_wr && mem_rd_idx == idx) return mem_result;
    return rf;
  endfunction

  function automatic logic needs_pending_load();
    logic reads_it;
    reads_it = (dec_use_rs1 && dec_rs1 == m.rd) || (dec_use_rs2 && dec_rs2 == m.rd);
    return dec_valid && m.valid && m.mrd && m.wr && reads_it;
  endfunction

  function automatic slot_t expected_next();
    slot_t s;
    if (reset || flush || needs_pending_load() || !dec_valid) return empty_slot();
    s.valid = 1'b1;
    s.op1   = reg_value(dec_rs1, dec_rs1_data);
    s.sd    = reg_value(dec_rs2, dec_rs2_data);
    s.op2   = dec_use_imm ? dec_imm : s.sd;
    s.op    = dec_alu_op;
    s.rd    = dec_rd;
    s.wr    = dec_reg_wr;
    s.mrd   = dec_mem_rd;
    s.mwr   = dec_mem_wr;
    s.pc    = dec_pc;
    return s;
  endfunction

  // One clock: check the combinational stall, advance, check every held field.
  task automatic step();
    slot_t nx;
    logic  exp_stall;
    #2;
    exp_stall  = needs_pending_load() && !flush && !reset;
    last_stall = stall;
    chk("stall", {31'b0, stall}, {31'b0, exp_stall});
    nx = expected_next();
    @(posedge clk);
    #1;
    m = nx;
    chk("ex_valid",     {31'b0, ex_valid},  {31'b0, m.valid});
    chk("ex_operand1",  ex_operand1,        m.op1);
    chk("ex_operand2",  ex_operand2,        m.op2);
    chk("ex_store_dat", ex_store_dat,       m.sd);
    chk("ex_alu_op",    {27'b0, ex_alu_op}, {27'b0, m.op});
    chk("ex_rd",        {28'b0, ex_rd},     {28'b0, m.rd});
    chk("ex_reg_wr",    {31'b0, ex_reg_wr}, {31'b0, m.wr});
    chk("ex_mem_rd",    {31'b0, ex_mem_rd}, {31'b0, m.mrd});
    chk("ex_mem_wr",    {31'b0, ex_mem_wr}, {31'b0, m.mwr});
    chk("ex_pc",        ex_pc,              m.pc);
  endtask

  task automatic drive(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic u1, input logic u2, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm, input logic ui, input logic [4:0] op,
                       input logic [3:0] rd, input logic wr, input logic mrd, input logic mwr,
                       input logic [31:0] pc);
    dec_valid = v; dec_rs1 = rs1; dec_rs2 = rs2; dec_use_rs1 = u1; dec_use_rs2 = u2;
    dec_rs1_data = d1; dec_rs2_data = d2; dec_imm = imm; dec_use_imm = ui;
    dec_alu_op = op; dec_rd = rd; dec_reg_wr = wr; dec_mem_rd = mrd; dec_mem_wr = mwr; dec_pc = pc;
  endtask

  initial begin
    m = empty_slot();
    last_stall = 1'b0;
    reset = 1'b1; flush = 1'b0;
    ex_alu_out = 32'h0; mem_rd_idx = 4'h0; mem_reg_wr = 1'b0; mem_result = 32'h0;
    drive(1, 4'd1, 4'd2, 1, 1, 32'h11, 32'h22, 32'h0, 0, ALU_ADD, 4'd3, 1, 0, 0, 32'h40);

    // Reset forces a bubble even with a valid decode.
    step();
    step();
    chk("t1_valid", {31'b0, ex_valid}, 32'h0);
    chk("t1_alu_op", {27'b0, ex_alu_op}, {27'b0, 5'b01001});
    chk("t1_operand1", ex_operand1, 32'h0);
    chk("t1_stall", {31'b0, last_stall}, 32'h0);
    reset = 1'b0;

    // ADD r1<=r2+r3 then dependent SUB r4<=r1-r2.
    drive(1, 4'd2, 4'd3, 1, 1, 32'd5, 32'd7, 32'h0, 0, ALU_ADD, 4'd1, 1, 0, 0, 32'h100);
    step();
    ex_alu_out = 32'd12;
    drive(1, 4'd1, 4'd2, 1, 1, 32'd0, 32'd5, 32'h0, 0, ALU_SUB, 4'd4, 1, 0, 0, 32'h104);
    step();
    chk("t2_operand1", ex_operand1, 32'd12);
    chk("t2_operand2", ex_operand2, 32'd5);

    // MEM forward, then EX overriding MEM for the same register.
    ex_alu_out = 32'd7; mem_rd_idx = 4'd1; mem_reg_wr = 1'b1; mem_result = 32'h99;
    drive(1, 4'd1, 4'd0, 1, 0, 32'h0, 32'h0, 32'd4, 1, ALU_ADD, 4'd1, 1, 0, 0, 32'h108);
    step();
    chk("t3_mem_fwd", ex_operand1, 32'h99);
    ex_alu_out = 32'h11;
    drive(1, 4'd1, 4'd0, 1, 0, 32'h0, 32'h0, 32'd0, 1, ALU_ADD, 4'd6, 1, 0, 0, 32'h10c);
    step();
    chk("t3_ex_over_mem", ex_operand1, 32'h11);
    mem_reg_wr = 1'b0;

    // Load-use: one stall cycle, then the load result arrives from MEM.
    drive(1, 4'd6, 4'd0, 1, 0, 32'h0, 32'h0, 32'h0, 1, ALU_ADD, 4'd5, 1, 1, 0, 32'h110);
    step();
    ex_alu_out = 32'h40;
    drive(1, 4'd5, 4'd2, 1, 1, 32'h0, 32'd5, 32'h0, 0, ALU_ADD, 4'd7, 1, 0, 0, 32'h114);
    step();
    chk("t4_stall", {31'b0, last_stall}, 32'h1);
    chk("t4_bubble", {31'b0, ex_valid}, 32'h0);
    mem_rd_idx = 4'd5; mem_reg_wr = 1'b1; mem_result = 32'hABCD;
    step();
    chk("t4_no_stall", {31'b0, last_stall}, 32'h0);
    chk("t4_load_fwd", ex_operand1, 32'hABCD);
    mem_reg_wr = 1'b0;

    // Flush on a load-use cycle wins: no stall, bubble captured.
    drive(1, 4'd0, 4'd0, 0, 0, 32'h0, 32'h0, 32'h8, 1, ALU_ADD, 4'd8, 1, 1, 0, 32'h118);
    step();
    drive(1, 4'd1, 4'd8, 1, 1, 32'h3, 32'h4, 32'h0, 0, ALU_OR, 4'd9, 1, 0, 0, 32'h11c);
    flush = 1'b1;
    step();
    chk("t5_stall", {31'b0, last_stall}, 32'h0);
    chk("t5_valid", {31'b0, ex_valid}, 32'h0);
    chk("t5_pc", ex_pc, 32'h0);
    flush = 1'b0;

    // Reset arriving mid-stall also drops the stall.
    drive(1, 4'd0, 4'd0, 0, 0, 32'h0, 32'h0, 32'h8, 1, ALU_ADD, 4'd9, 1, 1, 0, 32'h120);
    step();
    drive(1, 4'd9, 4'd0, 1, 0, 32'h3, 32'h4, 32'h0, 0, ALU_AND, 4'd2, 1, 0, 0, 32'h124);
    reset = 1'b1;
    step();
    chk("rst_stall", {31'b0, last_stall}, 32'h0);
    chk("rst_valid", {31'b0, ex_valid}, 32'h0);
    reset = 1'b0;

    // Store with immediate operand2 and forwarded store data.
    drive(1, 4'd2, 4'd3, 1, 1, 32'h1, 32'h2, 32'h0, 0, ALU_ADD, 4'd7, 1, 0, 0, 32'h128);
    step();
    ex_alu_out = 32'h1234;
    drive(1, 4'd3, 4'd7, 1, 1, 32'h5, 32'h6, 32'hFFFFFFF0, 1, ALU_ADD, 4'd0, 0, 0, 1, 32'h12c);
    step();
    chk("t6_operand2", ex_operand2, 32'hFFFFFFF0);
    chk("t6_store_dat", ex_store_dat, 32'h1234);

    // Random traffic; a stalled instruction is re-presented unchanged.
    for (int i = 0; i < 400; i++) begin
      if (!last_stall) begin
        dec_valid    = ($urandom_range(0, 7) != 0);
        dec_rs1      = 4'($urandom_range(0, 3));
        dec_rs2      = 4'($urandom_range(0, 3));
        dec_use_rs1  = 1'($urandom);
        dec_use_rs2  = 1'($urandom);
        dec_rs1_data = $urandom;
        dec_rs2_data = $urandom;
        dec_imm      = $urandom;
        dec_use_imm  = 1'($urandom);
        dec_alu_op   = 5'($urandom_range(0, 9));
        dec_rd       = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
        dec_reg_wr   = 1'($urandom);
        dec_mem_rd   = ($urandom_range(0, 2) == 0);
        dec_mem_wr   = ($urandom_range(0, 4) == 0);
        dec_pc       = $urandom;
      end
      ex_alu_out = $urandom;
      mem_rd_idx = 4'($urandom_range(0, 3));
      mem_reg_wr = 1'($urandom);
      mem_result = $urandom;
      flush      = ($urandom_range(0, 15) == 0);
      reset      = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
